// File: rtl/cnot_seq_pkg.sv
// rtl/cnot_seq_pkg.sv - shared types and helpers for the CNOT cascade sequencer
package cnot_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Program entries are stored at a fixed index width so the struct can live
  // here; narrower line indices are zero-extended on write.
  localparam int MAX_IDX_W = 8;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] ctrl;
    logic [MAX_IDX_W-1:0] tgt;
  } entry_t;

  function automatic logic entry_illegal(input entry_t e, input int width);
    return (e.ctrl == e.tgt) || (int'(e.ctrl) >= width) || (int'(e.tgt) >= width);
  endfunction

endpackage

// File: rtl/cnot_apply.sv
// rtl/cnot_apply.sv - single combinational CNOT step: work[tgt] ^= work[ctrl]
module cnot_apply
  import cnot_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] work,
  input  entry_t           op,
  output logic [WIDTH-1:0] work_next,
  output logic             illegal
);

  logic ctrl_bit;

  // Indices are matched by loop so out-of-range values never form a select.
  always_comb begin
    illegal   = entry_illegal(op, WIDTH);
    ctrl_bit  = 1'b0;
    work_next = work;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(op.ctrl) == i) ctrl_bit = work[i];
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (!illegal && int'(op.tgt) == i) work_next[i] = work[i] ^ ctrl_bit;
    end
  end

endmodule

// File: rtl/cnot_sequencer.sv
// rtl/cnot_sequencer.sv - program memory and control for forward/reverse CNOT cascades
module cnot_sequencer
  import cnot_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PROG_DEPTH = 16,
  parameter int IDX_W      = $clog2(WIDTH),
  parameter int AW         = $clog2(PROG_DEPTH),
  parameter int LW         = $clog2(PROG_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [IDX_W-1:0] prog_ctrl,
  input  logic [IDX_W-1:0] prog_tgt,
  input  logic [LW-1:0]    prog_len,
  input  logic             start,
  input  logic             reverse,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             err,
  output logic [LW-1:0]    op_count
);

  state_t           state, state_d;
  entry_t           mem [PROG_DEPTH];
  entry_t           op;
  logic [AW-1:0]    pc;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    len_eff;
  logic             rev_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic             illegal;
  logic             start_ok;
  logic             last_op;

  assign len_eff  = (prog_len > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : prog_len;
  assign start_ok = (state == IDLE) && start;
  assign last_op  = (op_count + LW'(1)) == len_q;
  assign op       = mem[pc];

  cnot_apply #(.WIDTH(WIDTH)) u_apply (
    .work      (work),
    .op        (op),
    .work_next (work_next),
    .illegal   (illegal)
  );

  // Program is writable only in IDLE so a run always sees a stable cascade.
  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE) begin
      mem[prog_addr] <= '{ctrl: MAX_IDX_W'(prog_ctrl), tgt: MAX_IDX_W'(prog_tgt)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = (len_eff == '0) ? DONE : RUN;
      RUN:  if (last_op) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work     <= '0;
      err      <= 1'b0;
      op_count <= '0;
      pc       <= '0;
      len_q    <= '0;
      rev_q    <= 1'b0;
    end else if (start_ok) begin
      work     <= data_in;
      len_q    <= len_eff;
      rev_q    <= reverse;
      pc       <= reverse ? AW'(len_eff - LW'(1)) : '0;
      err      <= 1'b0;
      op_count <= '0;
    end else if (state == RUN) begin
      work     <= work_next;
      err      <= err | illegal;
      op_count <= op_count + LW'(1);
      pc       <= rev_q ? pc - AW'(1) : pc + AW'(1);
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign data_out  = work;

endmodule

// File: tb/tb_cnot_sequencer.sv
// tb/tb_cnot_sequencer.sv - directed self-checking bench for cnot_sequencer (WIDTH=4)
module tb_cnot_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [2:0] prog_ctrl = '0;
  logic [2:0] prog_tgt = '0;
  logic [4:0] prog_len = '0;
  logic       start = 1'b0;
  logic       reverse = 1'b0;
  logic [3:0] data_in = '0;
  logic       busy;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] data_out;
  logic       err;
  logic [4:0] op_count;

  int tests = 0;
  int fails = 0;
  int lat;
  logic [3:0] rnd, fwd_res;

  always #5 clk = ~clk;

  cnot_sequencer #(.WIDTH(4), .PROG_DEPTH(16), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_ctrl (prog_ctrl),
    .prog_tgt  (prog_tgt),
    .prog_len  (prog_len),
    .start     (start),
    .reverse   (reverse),
    .data_in   (data_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err       (err),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_entry(input int addr, input int c, input int t);
    prog_we = 1'b1; prog_addr = 4'(addr); prog_ctrl = 3'(c); prog_tgt = 3'(t);
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // lat = edges after the start edge until out_valid is seen
  task automatic run(input int len, input logic rev, input logic [3:0] din, output int l);
    prog_len = 5'(len); reverse = rev; data_in = din; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 0;
    while (!out_valid && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    if (!out_valid) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [3:0] chain_fwd(input logic [3:0] d);
    logic [3:0] r;
    r = d;
    r[1] = r[1] ^ r[0];
    r[2] = r[2] ^ r[1];
    r[3] = r[3] ^ r[2];
    return r;
  endfunction

  initial begin
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_opcnt", 32'(op_count), 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    write_entry(0, 0, 1);
    write_entry(1, 1, 2);
    write_entry(2, 2, 3);

    // forward chain
    run(3, 1'b0, 4'b0001, lat);
    check("fwd_lat", 32'(lat), 32'd3);
    check("fwd_busy", 32'(busy), 32'd1);
    check("fwd_data", 32'(data_out), 32'hf);
    check("fwd_opcnt", 32'(op_count), 32'd3);
    check("fwd_err", 32'(err), 32'd0);
    ack();
    check("ack_valid", 32'(out_valid), 32'd0);
    check("ack_busy", 32'(busy), 32'd0);
    check("ack_retain", 32'(data_out), 32'hf);

    // inverse
    run(3, 1'b1, 4'b1111, lat);
    check("rev_lat", 32'(lat), 32'd3);
    check("rev_data", 32'(data_out), 32'h1);
    ack();

    // random round trip
    rnd = 4'($urandom_range(0, 15));
    run(3, 1'b0, rnd, lat);
    fwd_res = data_out;
    check("rnd_fwd", 32'(fwd_res), 32'(chain_fwd(rnd)));
    ack();
    run(3, 1'b1, fwd_res, lat);
    check("rnd_back", 32'(data_out), 32'(rnd));
    ack();

    // illegal entries
    write_entry(0, 2, 2);
    write_entry(1, 5, 0);
    run(2, 1'b0, 4'b1010, lat);
    check("ill_data", 32'(data_out), 32'ha);
    check("ill_err", 32'(err), 32'd1);
    check("ill_opcnt", 32'(op_count), 32'd2);
    ack();
    check("ill_sticky", 32'(err), 32'd1);

    // empty program, also clears err
    run(0, 1'b0, 4'b0110, lat);
    check("empty_lat", 32'(lat), 32'd0);
    check("empty_data", 32'(data_out), 32'h6);
    check("empty_err", 32'(err), 32'd0);
    check("empty_opcnt", 32'(op_count), 32'd0);
    ack();

    // backpressure with ignored start / prog_we
    write_entry(0, 0, 1);
    write_entry(1, 1, 2);
    run(3, 1'b0, 4'b0001, lat);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1); prog_we = (i == 2); prog_addr = 4'd0;
      prog_ctrl = 3'd3; prog_tgt = 3'd3; data_in = 4'b0000; prog_len = 5'd1;
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(data_out), 32'hf);
    end
    start = 1'b0; prog_we = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    check("hs_valid", 32'(out_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("hs_start_ign", 32'(busy), 32'd0);
    run(3, 1'b0, 4'b0001, lat);
    check("prog_kept", 32'(data_out), 32'hf);
    check("prog_kept_err", 32'(err), 32'd0);
    ack();

    // asynchronous reset mid-run
    prog_len = 5'd3; reverse = 1'b0; data_in = 4'b0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_data", 32'(data_out), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    run(3, 1'b0, 4'b0001, lat);
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_data", 32'(data_out), 32'hf);
    ack();

    // length clamp: entries 3..15 are illegal no-ops
    for (int a = 3; a < 16; a++) write_entry(a, 0, 0);
    run(31, 1'b0, 4'b0001, lat);
    check("clamp_lat", 32'(lat), 32'd16);
    check("clamp_opcnt", 32'(op_count), 32'd16);
    check("clamp_data", 32'(data_out), 32'hf);
    check("clamp_err", 32'(err), 32'd1);
    ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
